// File: rtl/bus_map_pkg.sv
// Address map, region/state enums and small helpers shared by the memory bus arbiter.
package bus_map_pkg;

    localparam logic [63:0] ROM_BASE     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ROM_SIZE     = 64'h0000_0000_0000_1000;
    localparam logic [63:0] RAM_BASE     = 64'h0000_0000_0000_1000;
    localparam logic [63:0] RAM_SIZE     = 64'h0000_0000_0000_2000;
    localparam logic [63:0] UART_ADDR    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] KEY_ADDR     = 64'h0000_0000_8000_0010;
    localparam logic [63:0] BUS_DEADBEEF = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_UART,
        REG_KEY,
        REG_NONE
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } arb_state_t;

    function automatic logic [63:0] zext32(input logic [31:0] w);
        return {32'd0, w};
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational byte-address decode into a bus region plus ROM/RAM word indices.
module mem_addr_decode
    import bus_map_pkg::*;
#(
    parameter int ROM_AW = 10,
    parameter int RAM_AW = 11
) (
    input  logic [63:0]       addr_i,
    output region_t           region_o,
    output logic [ROM_AW-1:0] rom_idx_o,
    output logic [RAM_AW-1:0] ram_idx_o
);

    // Unsigned offset compares cover both bounds of each window at once.
    always_comb begin
        if ((addr_i - ROM_BASE) < ROM_SIZE) begin
            region_o = REG_ROM;
        end else if ((addr_i - RAM_BASE) < RAM_SIZE) begin
            region_o = REG_RAM;
        end else if (addr_i == UART_ADDR) begin
            region_o = REG_UART;
        end else if (addr_i == KEY_ADDR) begin
            region_o = REG_KEY;
        end else begin
            region_o = REG_NONE;
        end
    end

    assign rom_idx_o = ROM_AW'((addr_i[ROM_AW+1:0] - ROM_BASE[ROM_AW+1:0]) >> 2);
    assign ram_idx_o = RAM_AW'((addr_i[RAM_AW+1:0] - RAM_BASE[RAM_AW+1:0]) >> 2);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrated, sequenced access engine sharing ROM/RAM/UART/KEY between fetch and load/store.
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT data grants.
module mem_bus_arbiter
    import bus_map_pkg::*;
#(
    parameter int ROM_WORDS    = 1024,
    parameter int RAM_WORDS    = 2048,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         if_req,
    input  logic [31:0]                  if_addr,
    output logic [31:0]                  if_rdata,
    output logic                         if_valid,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [63:0]                  d_addr,
    input  logic [63:0]                  d_wdata,
    output logic [63:0]                  d_rdata,
    output logic                         d_valid,
    output logic [$clog2(ROM_WORDS)-1:0] rom_addr,
    input  logic [31:0]                  rom_rdata,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic                         ram_we,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    output logic                         uart_wr,
    output logic [31:0]                  uart_wdata,
    input  logic [7:0]                   key_data
);

    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);

    arb_state_t        state_q;
    logic              gnt_data_q;
    logic              we_q;
    region_t           region_q;
    logic [7:0]        key_q;

    logic [31:0]       if_rdata_q;
    logic              if_valid_q;
    logic [63:0]       d_rdata_q;
    logic              d_valid_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [31:0]       ram_wdata_q;
    logic              uart_wr_q;
    logic [31:0]       uart_wdata_q;

    logic              any_req;
    logic              gnt_data_d;
    logic [63:0]       sel_addr;
    region_t           sel_region;
    logic [ROM_AW-1:0] sel_rom_idx;
    logic [RAM_AW-1:0] sel_ram_idx;
    logic [63:0]       d_rdata_d;
    logic [31:0]       if_rdata_d;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^d_wdata[63:32];
    assign any_req         = if_req | d_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_q;
    logic [SCW-1:0] starve_d;
    logic           starved;

    assign starved    = (starve_q == SCW'(STARVE_LIMIT));
    assign gnt_data_d = d_req & ~(if_req & starved);

    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (if_req && !gnt_data_d) begin
                starve_d = '0;
            end else if (gnt_data_d && if_req && !starved) begin
                starve_d = starve_q + SCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority; the limit stays in the parameter list so both builds share one interface.
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign gnt_data_d = d_req;
`endif

    assign sel_addr = gnt_data_d ? d_addr : {32'd0, if_addr};

    mem_addr_decode #(
        .ROM_AW (ROM_AW),
        .RAM_AW (RAM_AW)
    ) u_decode (
        .addr_i    (sel_addr),
        .region_o  (sel_region),
        .rom_idx_o (sel_rom_idx),
        .ram_idx_o (sel_ram_idx)
    );

    // Writes, UART and unmapped accesses all answer with the DEADBEEF pattern.
    always_comb begin
        d_rdata_d  = BUS_DEADBEEF;
        if_rdata_d = BUS_DEADBEEF[31:0];
        if (!we_q) begin
            case (region_q)
                REG_ROM: begin
                    d_rdata_d  = zext32(rom_rdata);
                    if_rdata_d = rom_rdata;
                end
                REG_RAM: begin
                    d_rdata_d  = zext32(ram_rdata);
                    if_rdata_d = ram_rdata;
                end
                REG_KEY: d_rdata_d = {56'd0, key_q};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_data_q   <= 1'b0;
            we_q         <= 1'b0;
            region_q     <= REG_NONE;
            key_q        <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_valid_q    <= 1'b0;
            rom_addr_q   <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            uart_wr_q    <= 1'b0;
            uart_wdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            uart_wr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_q    <= S_ACCESS;
                        gnt_data_q <= gnt_data_d;
                        we_q       <= gnt_data_d & d_we;
                        region_q   <= sel_region;
                        if (sel_region == REG_ROM) begin
                            rom_addr_q <= sel_rom_idx;
                        end
                        if (sel_region == REG_RAM) begin
                            ram_addr_q <= sel_ram_idx;
                        end
                        // Strobes set here are high for exactly the ACCESS cycle.
                        if (gnt_data_d && d_we && sel_region == REG_RAM) begin
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= d_wdata[31:0];
                        end
                        if (gnt_data_d && d_we && sel_region == REG_UART) begin
                            uart_wr_q    <= 1'b1;
                            uart_wdata_q <= {24'd0, d_wdata[7:0]};
                        end
                    end
                end
                S_ACCESS: begin
                    key_q   <= key_data;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    if (gnt_data_q) begin
                        d_valid_q <= 1'b1;
                        d_rdata_q <= d_rdata_d;
                    end else begin
                        if_valid_q <= 1'b1;
                        if_rdata_q <= if_rdata_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign d_rdata    = d_rdata_q;
    assign d_valid    = d_valid_q;
    assign rom_addr   = rom_addr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign uart_wr    = uart_wr_q;
    assign uart_wdata = uart_wdata_q;

endmodule
